// File: rtl/adc_frame_reader_if.sv
// Bus bundle between the ADC frame reader, the capture FIFO read port and
// the host readout logic. The reader is the master; the FIFO/host side is
// the slave.
interface adc_frame_reader_if #(
  parameter int FRAME_W = 24
);
  // Frame control from the host register block
  logic               start;
  logic [FRAME_W-1:0] frame_len;
  logic [1:0]         data_format;
  logic [1:0]         ch_sel;
  // Capture FIFO read port
  logic [127:0]       fifo_dout;
  logic               fifo_empty;
  logic               fifo_rden;
  // Host readout handshake
  logic               rden_host;
  logic [15:0]        dout;
  logic               dout_valid;
  // Status
  logic               busy;
  logic               frame_done;

  modport master (
    input  start, frame_len, data_format, ch_sel,
    input  fifo_dout, fifo_empty, rden_host,
    output fifo_rden, dout, dout_valid, busy, frame_done
  );

  modport slave (
    output start, frame_len, data_format, ch_sel,
    output fifo_dout, fifo_empty, rden_host,
    input  fifo_rden, dout, dout_valid, busy, frame_done
  );
endinterface

// File: rtl/adc_frame_reader.sv
// ADC frame reader: drains 128-bit capture words from the capture FIFO,
// extracts the samples of one channel according to the acquisition format
// and hands them to the host as 16-bit {later, earlier} sample pairs.
module adc_frame_reader #(
  parameter int FRAME_W = 24
) (
  input  logic               rd_clk,
  input  logic               rd_rst,
  adc_frame_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [1:0]         fmt_reg, fmt_next;
  logic [1:0]         ch_reg, ch_next;
  logic [FRAME_W-1:0] len_reg, len_next;
  logic [FRAME_W-1:0] word_cnt_reg, word_cnt_next;
  logic [2:0]         idx_reg, idx_next;
  logic [127:0]       hold_reg, hold_next;

  // Candidate pairs for every format, all derived from the hold register
  logic [15:0] pair_single [8];
  logic [15:0] pair_raw    [8];
  logic [15:0] pair_dual   [4];
  logic [15:0] pair_quad   [2];
  logic [31:0] quad_chunk;
  logic [15:0] pair_sel;
  logic [2:0]  last_idx;

  logic        fifo_rden;
  logic [15:0] dout;
  logic        dout_valid;
  logic        busy;
  logic        frame_done;

  genvar gi;

  // Single-channel and raw pairs: eight per word. In single-channel mode
  // consecutive samples rotate through the four chunks before advancing a
  // byte, so sample k lives in chunk k%4, byte k/4.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_eight
      localparam int KE = 2 * gi;
      localparam int KO = 2 * gi + 1;
      assign pair_single[gi] = {hold_reg[(KO % 4) * 32 + (KO / 4) * 8 +: 8],
                                hold_reg[(KE % 4) * 32 + (KE / 4) * 8 +: 8]};
      assign pair_raw[gi]    = hold_reg[16 * gi +: 16];
    end
  endgenerate

  // Dual-channel pairs: channel x alternates between chunks 2x and 2x+1,
  // so each pair takes the same byte lane from both chunks.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dual
      assign pair_dual[gi] = ch_reg[0] ?
        {hold_reg[96 + 8 * gi +: 8], hold_reg[64 + 8 * gi +: 8]} :
        {hold_reg[32 + 8 * gi +: 8], hold_reg[ 0 + 8 * gi +: 8]};
    end
  endgenerate

  // Quad-channel: the selected chunk holds four consecutive samples
  always_comb begin
    quad_chunk = hold_reg[31:0];
    case (ch_reg)
      2'd0:    quad_chunk = hold_reg[31:0];
      2'd1:    quad_chunk = hold_reg[63:32];
      2'd2:    quad_chunk = hold_reg[95:64];
      default: quad_chunk = hold_reg[127:96];
    endcase
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_quad
      assign pair_quad[gi] = quad_chunk[16 * gi +: 16];
    end
  endgenerate

  // Pick the pair at the current index and the last valid index per format
  always_comb begin
    pair_sel = 16'h0000;
    last_idx = 3'd7;
    case (fmt_reg)
      2'b00: begin
        pair_sel = pair_single[idx_reg];
        last_idx = 3'd7;
      end
      2'b01: begin
        pair_sel = pair_dual[idx_reg[1:0]];
        last_idx = 3'd3;
      end
      2'b10: begin
        pair_sel = pair_quad[idx_reg[0]];
        last_idx = 3'd1;
      end
      default: begin
        pair_sel = pair_raw[idx_reg];
        last_idx = 3'd7;
      end
    endcase
  end

  // Next-state and output decode; config is captured only when a start is
  // accepted in IDLE so the host may change it freely mid-frame.
  always_comb begin
    state_next    = state_reg;
    fmt_next      = fmt_reg;
    ch_next       = ch_reg;
    len_next      = len_reg;
    word_cnt_next = word_cnt_reg;
    idx_next      = idx_reg;
    hold_next     = hold_reg;
    fifo_rden     = 1'b0;
    dout          = 16'h0000;
    dout_valid    = 1'b0;
    busy          = (state_reg != S_IDLE);
    frame_done    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          fmt_next      = bus.data_format;
          ch_next       = bus.ch_sel;
          len_next      = bus.frame_len;
          word_cnt_next = '0;
          state_next    = (bus.frame_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        fifo_rden = !bus.fifo_empty;
        if (!bus.fifo_empty) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        hold_next     = bus.fifo_dout;
        idx_next      = 3'd0;
        word_cnt_next = word_cnt_reg + 1'b1;
        state_next    = S_SHIFT;
      end
      S_SHIFT: begin
        dout_valid = 1'b1;
        dout       = pair_sel;
        if (bus.rden_host) begin
          if (idx_reg == last_idx) begin
            state_next = (word_cnt_reg == len_reg) ? S_DONE : S_FETCH;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any held word
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_reg    <= S_IDLE;
      fmt_reg      <= 2'b00;
      ch_reg       <= 2'b00;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      idx_reg      <= 3'd0;
      hold_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      fmt_reg      <= fmt_next;
      ch_reg       <= ch_next;
      len_reg      <= len_next;
      word_cnt_reg <= word_cnt_next;
      idx_reg      <= idx_next;
      hold_reg     <= hold_next;
    end
  end

  assign bus.fifo_rden  = fifo_rden;
  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_adc_frame_reader.sv
// Directed bench for adc_frame_reader with a small FIFO model and a
// sample-level reference model of the channel extraction.
module tb_adc_frame_reader;

  localparam int FRAME_W = 24;

  localparam logic [127:0] W00 = 128'h0F0B0703_0E0A0602_0D090501_0C080400;
  localparam logic [127:0] W01 = 128'h27252321_26242220_55555555_AAAAAAAA;
  localparam logic [127:0] W10 = 128'h99999999_43424140_77777777_66666666;
  localparam logic [127:0] W11 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_frame_reader_if #(.FRAME_W(FRAME_W)) bus ();

  adc_frame_reader #(.FRAME_W(FRAME_W)) dut (
    .rd_clk (clk),
    .rd_rst (rst),
    .bus    (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // FIFO model
  logic [127:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (bus.fifo_rden) begin
      bus.fifo_dout <= fifo_mem[rd_ptr[5:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Scoreboard state
  logic [15:0] exp_q [$];
  int done_cd  = 0;
  int accepted = 0;
  logic rden0, busy0;
  logic [15:0] first_dout;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: sample j of a word for a given format/channel
  function automatic logic [7:0] samp(input logic [127:0] w, input logic [1:0] fmt,
                                      input logic [1:0] ch, input int j);
    int c;
    int b;
    case (fmt)
      2'b00:   begin c = j % 4; b = j / 4; end
      2'b01:   begin c = 2 * int'(ch[0]) + j % 2; b = j / 2; end
      default: begin c = int'(ch); b = j; end
    endcase
    return w[c * 32 + b * 8 +: 8];
  endfunction

  function automatic int npairs(input logic [1:0] fmt);
    case (fmt)
      2'b01:   return 4;
      2'b10:   return 2;
      default: return 8;
    endcase
  endfunction

  function automatic logic [15:0] model_pair(input logic [127:0] w, input logic [1:0] fmt,
                                             input logic [1:0] ch, input int i);
    if (fmt == 2'b11) return w[16 * i +: 16];
    return {samp(w, fmt, ch, 2 * i + 1), samp(w, fmt, ch, 2 * i)};
  endfunction

  // Compare process: every cycle, dout against the expected pair stream,
  // dout=0 when not valid, and frame_done exactly one cycle after the final accept
  always @(negedge clk) begin
    if (!rst) begin
      check("frame_done", 128'(bus.frame_done), 128'(done_cd == 1));
      if (done_cd > 0) done_cd--;
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 128'(bus.dout_valid), 128'(0));
        end else begin
          check("dout", 128'(bus.dout), 128'(exp_q[0]));
          if (bus.rden_host) begin
            void'(exp_q.pop_front());
            accepted++;
            if (exp_q.size() == 0) done_cd = 1;
          end
        end
      end else begin
        check("idle_dout", 128'(bus.dout), 128'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [127:0] w);
    fifo_mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  task automatic queue_expect(input logic [127:0] w, input logic [1:0] fmt, input logic [1:0] ch);
    for (int i = 0; i < npairs(fmt); i++) exp_q.push_back(model_pair(w, fmt, ch, i));
  endtask

  // Pulse start for one cycle, then scramble the config inputs
  task automatic start_frame(input logic [1:0] fmt, input logic [1:0] ch, input int len);
    bus.data_format = fmt;
    bus.ch_sel      = ch;
    bus.frame_len   = FRAME_W'(len);
    bus.start       = 1'b1;
    if (len == 0) done_cd = 2;
    @(negedge clk);
    rden0 = bus.fifo_rden;
    busy0 = bus.busy;
    tick();
    bus.start       = 1'b0;
    bus.data_format = ~fmt;
    bus.ch_sel      = ~ch;
    bus.frame_len   = FRAME_W'(len + 7);
    $display("[TB] start fmt=%0d ch=%0d len=%0d", fmt, ch, len);
  endtask

  task automatic wait_valid(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.dout_valid) begin
        found = 1'b1;
        first_dout = bus.dout;
        break;
      end
    end
    check(name, 128'(found), 128'(1));
    tick();
  endtask

  task automatic wait_done(input string name, input bit toggle);
    logic got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin
        got = 1'b1;
        break;
      end
      tick();
      if (toggle) bus.rden_host = ~bus.rden_host;
    end
    check({name, "_done_seen"}, 128'(got), 128'(1));
    check({name, "_busy_in_done"}, 128'(bus.busy), 128'(1));
    check({name, "_pairs_left"}, 128'(exp_q.size()), 128'(0));
    tick();
    bus.rden_host = 1'b1;
    @(negedge clk);
    check({name, "_busy_after"}, 128'(bus.busy), 128'(0));
    $display("[TB] frame %s complete, %0d pairs accepted so far", name, accepted);
    tick();
  endtask

  initial begin
    int acc0;
    int ptr0;
    bus.start       = 1'b0;
    bus.frame_len   = '0;
    bus.data_format = 2'b00;
    bus.ch_sel      = 2'b00;
    bus.rden_host   = 1'b1;
    bus.fifo_dout   = '0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_dout", 128'(bus.dout), 128'(0));
    check("rst_dout_valid", 128'(bus.dout_valid), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_frame_done", 128'(bus.frame_done), 128'(0));
    check("rst_fifo_rden", 128'(bus.fifo_rden), 128'(0));
    tick();
    rst = 1'b0;
    tick();

    // Pin the reference model with hand-computed pairs
    check("model_f00_p0", 128'(model_pair(W00, 2'b00, 2'd0, 0)), 128'(16'h0100));
    check("model_f00_p7", 128'(model_pair(W00, 2'b00, 2'd0, 7)), 128'(16'h0F0E));
    check("model_f01_p0", 128'(model_pair(W01, 2'b01, 2'd1, 0)), 128'(16'h2120));
    check("model_f01_p3", 128'(model_pair(W01, 2'b01, 2'd1, 3)), 128'(16'h2726));
    check("model_f10_p0", 128'(model_pair(W10, 2'b10, 2'd2, 0)), 128'(16'h4140));
    check("model_f10_p1", 128'(model_pair(W10, 2'b10, 2'd2, 1)), 128'(16'h4342));
    check("model_f11_p7", 128'(model_pair(W11, 2'b11, 2'd0, 7)), 128'(16'h0F0E));

    // Format 00, one word, with start latency
    push_word(W00);
    queue_expect(W00, 2'b00, 2'd0);
    start_frame(2'b00, 2'd0, 1);
    check("lat_rden_c0", 128'(rden0), 128'(0));
    check("lat_busy_c0", 128'(busy0), 128'(0));
    @(negedge clk);
    check("lat_rden_c1", 128'(bus.fifo_rden), 128'(1));
    check("lat_valid_c1", 128'(bus.dout_valid), 128'(0));
    tick();
    @(negedge clk);
    check("lat_rden_c2", 128'(bus.fifo_rden), 128'(0));
    check("lat_valid_c2", 128'(bus.dout_valid), 128'(0));
    tick();
    @(negedge clk);
    check("lat_valid_c3", 128'(bus.dout_valid), 128'(1));
    check("lat_dout_c3", 128'(bus.dout), 128'(16'h0100));
    tick();
    wait_done("f00", 1'b0);

    // Format 01, channel 1
    push_word(W01);
    queue_expect(W01, 2'b01, 2'd1);
    start_frame(2'b01, 2'd1, 1);
    wait_valid("f01_valid");
    check("f01_first", 128'(first_dout), 128'(16'h2120));
    wait_done("f01", 1'b0);

    // Format 10, channel 2
    push_word(W10);
    queue_expect(W10, 2'b10, 2'd2);
    start_frame(2'b10, 2'd2, 1);
    wait_valid("f10_valid");
    check("f10_first", 128'(first_dout), 128'(16'h4140));
    wait_done("f10", 1'b0);

    // Raw format, three words, host accepting every other cycle
    acc0 = accepted;
    push_word(W11);
    push_word(W00);
    push_word(W01);
    queue_expect(W11, 2'b11, 2'd0);
    queue_expect(W00, 2'b11, 2'd0);
    queue_expect(W01, 2'b11, 2'd0);
    start_frame(2'b11, 2'd0, 3);
    wait_done("f11x3", 1'b1);
    check("f11x3_count", 128'(accepted - acc0), 128'(24));

    // Empty FIFO stall, then fill
    start_frame(2'b00, 2'd0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("empty_rden", 128'(bus.fifo_rden), 128'(0));
      check("empty_valid", 128'(bus.dout_valid), 128'(0));
      tick();
    end
    push_word(W01);
    queue_expect(W01, 2'b00, 2'd0);
    @(negedge clk);
    check("fill_rden", 128'(bus.fifo_rden), 128'(1));
    tick();
    @(negedge clk);
    check("fill_valid_c1", 128'(bus.dout_valid), 128'(0));
    tick();
    @(negedge clk);
    check("fill_valid_c2", 128'(bus.dout_valid), 128'(1));
    check("fill_dout", 128'(bus.dout), 128'(16'h55AA));
    tick();
    wait_done("empty", 1'b0);

    // Zero-length frame
    ptr0 = rd_ptr;
    push_word(W10);
    start_frame(2'b00, 2'd0, 0);
    check("len0_rden_c0", 128'(rden0), 128'(0));
    @(negedge clk);
    check("len0_done_c1", 128'(bus.frame_done), 128'(1));
    check("len0_rden_c1", 128'(bus.fifo_rden), 128'(0));
    tick();
    @(negedge clk);
    check("len0_busy_c2", 128'(bus.busy), 128'(0));
    check("len0_no_read", 128'(rd_ptr), 128'(ptr0));
    tick();

    // Second start while busy is ignored (W10 still pending in the FIFO)
    acc0 = accepted;
    push_word(W00);
    queue_expect(W10, 2'b00, 2'd0);
    start_frame(2'b00, 2'd0, 1);
    wait_valid("ign_valid");
    bus.start       = 1'b1;
    bus.data_format = 2'b11;
    bus.frame_len   = FRAME_W'(5);
    tick();
    bus.start = 1'b0;
    wait_done("ignore", 1'b0);
    check("ign_count", 128'(accepted - acc0), 128'(8));
    check("ign_rdptr", 128'(rd_ptr), 128'(ptr0 + 1));

    // Reset in the middle of SHIFT (W00 left over, then W11, W01)
    ptr0 = rd_ptr;
    push_word(W11);
    push_word(W01);
    queue_expect(W00, 2'b11, 2'd0);
    queue_expect(W11, 2'b11, 2'd0);
    start_frame(2'b11, 2'd0, 2);
    wait_valid("rst_valid");
    tick();
    tick();
    bus.rden_host = 1'b0;
    rst = 1'b1;
    tick();
    exp_q.delete();
    done_cd = 0;
    @(negedge clk);
    check("midrst_dout", 128'(bus.dout), 128'(0));
    check("midrst_valid", 128'(bus.dout_valid), 128'(0));
    check("midrst_busy", 128'(bus.busy), 128'(0));
    check("midrst_done", 128'(bus.frame_done), 128'(0));
    check("midrst_rden", 128'(bus.fifo_rden), 128'(0));
    check("midrst_rdptr", 128'(rd_ptr), 128'(ptr0 + 1));
    tick();
    rst = 1'b0;
    bus.rden_host = 1'b1;
    tick();
    queue_expect(fifo_mem[rd_ptr[5:0]], 2'b10, 2'd2);
    start_frame(2'b10, 2'd2, 1);
    wait_valid("post_rst_valid");
    check("post_rst_first", 128'(first_dout), 128'(16'h0908));
    wait_done("post_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/adc_frame_reader.md
# adc_frame_reader

Read-side counterpart to the ADC capture path. It drains stored 128-bit capture words (four 32-bit lane chunks A/C/B/D packed per acquisition format) from the capture FIFO. It de-interleaves the samples of one selected channel and presents them to the host readout bus as 16-bit words, each holding two consecutive 8-bit samples. It sits between the capture FIFO read port and the host register/readout logic, next to the scan readout path.

## Interface
Parameters:
- FRAME_W, 24, width of `frame_len` and the word counter

Ports:
- `rd_clk`  in  1  single clock for all logic
- `rd_rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a frame read (ignored unless IDLE)
- `frame_len`  in  FRAME_W  number of 128-bit words to read; sampled on `start`
- `data_format`  in  2  00 single-ch, 01 dual-ch, 10 quad-ch, 11 raw; sampled on `start`
- `ch_sel`  in  2  channel to extract (01: bit0 only; 10: 0..3); sampled on `start`
- `fifo_dout`  in  128  FIFO read data, valid the cycle after `fifo_rden`
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rden`  out  1  FIFO read strobe
- `rden_host`  in  1  host accepts current `dout`
- `dout`  out  16  {later sample, earlier sample}
- `dout_valid`  out  1  `dout` holds a valid pair
- `busy`  out  1  high in any state except IDLE
- `frame_done`  out  1  one-cycle pulse when the last pair is accepted

## Operation
- Sample k of a word means bits [c*32 + b*8 +: 8].
- Format 00: 16 samples per word; sample k has c=k%4, b=k/4. Output 8 pairs: pair i = {s(2i+1), s(2i)}.
- Format 01: channel x=ch_sel[0]; sample j (0..7) has c=2x+j%2, b=j/2. Output 4 pairs.
- Format 10: channel c=ch_sel; sample j (0..3) has b=j. Output 2 pairs.
- Format 11: raw; pair i = bits[16i+:16]. Output 8 pairs.
- FSM states:
  - IDLE: wait for `start`. If frame_len=0, go to DONE; else go to FETCH.
  - FETCH: `fifo_rden` = !fifo_empty, driven combinationally. When asserted, go to WAIT.
  - WAIT: latch `fifo_dout` into the hold register, clear pair index, increment word count, go to SHIFT.
  - SHIFT: `dout_valid`=1. `dout` = pair[index] from the hold register. On `rden_host`, index advances. On accepting the last pair: if word count = frame_len, go to DONE; else go to FETCH.
  - DONE: `frame_done`=1 for one cycle, then IDLE.
- `start` is ignored while busy.
- Config changes mid-frame have no effect; `data_format`, `ch_sel` and `frame_len` are latched copies.
- Outside SHIFT, `dout`=0 and `dout_valid`=0.
- Word counter is FRAME_W bits; frame_len = 2^FRAME_W−1 is the maximum and must not wrap.

## Timing
- Reset values: `fifo_rden`=0, `dout`=0, `dout_valid`=0, `busy`=0, `frame_done`=0, state IDLE, counters 0.
- `rd_rst` mid-frame: back to IDLE on the next edge. The hold register is discarded and the FIFO is not read further.
- Start latency with a non-empty FIFO:
  - `start` in cycle 0.
  - `fifo_rden` in cycle 1.
  - Capture in cycle 2.
  - `dout_valid` from cycle 3.
- With `rden_host` held high, one pair is accepted per cycle.
- Word gap is 2 cycles: FETCH plus WAIT between the last pair of word n and the first pair of word n+1.
- An empty FIFO stalls in FETCH indefinitely with `fifo_rden`=0. There is no timeout.
- `rden_host` while `dout_valid`=0 is ignored.
- `frame_done` is asserted the cycle after the final accepted pair. `busy` drops the cycle after that.

## Test plan
- Format 00, frame_len=1: the word has byte (k%4)*32+(k/4)*8 = k. Expect `dout` = 0x0100, 0x0302, …, 0x0F0E (8 pairs), then `frame_done`.
- Format 01, ch_sel=1: chunks 2/3 bytes set so sample j = 0x20+j. Expect 0x2120, 0x2322, 0x2524, 0x2726. Format 10, ch_sel=2: chunk 2 bytes 0x40..0x43. Expect 0x4140, 0x4342.
- Format 11, word = 128'h0F0E…0100. Expect 0x0100 … 0x0F0E. frame_len=3 with `rden_host` toggling every other cycle: 24 pairs total, no drops or duplicates.
- FIFO empty for 10 cycles after `start`: `fifo_rden` stays 0 and `dout_valid` stays 0. When the FIFO fills, the read proceeds with 3-cycle latency.
- frame_len=0: `frame_done` 1 cycle after `start`, no `fifo_rden`. A second `start` during a frame is ignored, and the pair count is unchanged.
- `rd_rst` asserted mid-SHIFT: next cycle all outputs are 0 and state is IDLE. A new `start` then reads correctly from the next FIFO word.
